// File: rtl/logic_op_pipe.sv
// logic_op_pipe: registered bitwise/logical/reduction operator slice with a
// valid/ready handshake on both sides and a 2-entry skid stage.
//
// Ports:
//   clk, rst_n            single rising-edge clock, synchronous active-low reset
//   in_valid/in_ready     operand beat handshake (in_ready is a register output)
//   in_a, in_b, in_op     operands and 4-bit operator code
//   out_valid/out_ready   result beat handshake
//   out_data, out_err     result and illegal-opcode flag
//   op_count              completed output handshakes (wraps)
//   xz_flag               (LOGIC_OP_XCHK_EN only) an operand had x/z bits
//
// Optional feature macro: LOGIC_OP_XCHK_EN adds the xz_flag output.

module logic_op_pipe #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
`ifdef LOGIC_OP_XCHK_EN
  output logic             xz_flag,
`endif
  output logic [CNT_W-1:0] op_count
);

  localparam logic [3:0] OP_NOT  = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_XNOR = 4'd4;
  localparam logic [3:0] OP_LNOT = 4'd5;
  localparam logic [3:0] OP_LAND = 4'd6;
  localparam logic [3:0] OP_LOR  = 4'd7;
  localparam logic [3:0] OP_RAND = 4'd8;
  localparam logic [3:0] OP_ROR  = 4'd9;
  localparam logic [3:0] OP_RXOR = 4'd10;
  localparam logic [3:0] OP_NAND = 4'd11;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] or_data_q, or_data_d;
  logic             or_err_q, or_err_d;
  logic [WIDTH-1:0] sr_data_q, sr_data_d;
  logic             sr_err_q, sr_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept_c;
  logic             deliver_c;
  logic [WIDTH-1:0] res_c;
  logic             err_c;
  logic             bit_c;

`ifdef LOGIC_OP_XCHK_EN
  logic or_xz_q, or_xz_d;
  logic sr_xz_q, sr_xz_d;
  logic xz_c;
  logic binary_c;

  // 4-state check: reduction-XOR of any x/z bit yields x.
  always_comb begin
    binary_c = (in_op inside {OP_AND, OP_OR, OP_XOR, OP_XNOR, OP_LAND, OP_LOR, OP_NAND});
    xz_c     = ((^in_a) === 1'bx) || (binary_c && ((^in_b) === 1'bx));
  end
`endif

  assign accept_c  = in_valid && in_ready_q;
  assign deliver_c = out_valid_q && out_ready;

  // Operator datapath; 1-bit results land in bit 0 and are zero-extended.
  always_comb begin
    res_c = '0;
    err_c = 1'b0;
    bit_c = 1'b0;
    case (in_op)
      OP_NOT:  res_c = ~in_a;
      OP_AND:  res_c = in_a & in_b;
      OP_OR:   res_c = in_a | in_b;
      OP_XOR:  res_c = in_a ^ in_b;
      OP_XNOR: res_c = in_a ~^ in_b;
      OP_LNOT: begin bit_c = !in_a;         res_c = WIDTH'(bit_c); end
      OP_LAND: begin bit_c = in_a && in_b;  res_c = WIDTH'(bit_c); end
      OP_LOR:  begin bit_c = in_a || in_b;  res_c = WIDTH'(bit_c); end
      OP_RAND: begin bit_c = &in_a;         res_c = WIDTH'(bit_c); end
      OP_ROR:  begin bit_c = |in_a;         res_c = WIDTH'(bit_c); end
      OP_RXOR: begin bit_c = ^in_a;         res_c = WIDTH'(bit_c); end
      OP_NAND: res_c = ~(in_a & in_b);
      default: err_c = 1'b1;
    endcase
  end

  // Skid FSM: OR feeds the output, SR catches one beat while stalled.
  always_comb begin
    state_d   = state_q;
    or_data_d = or_data_q;
    or_err_d  = or_err_q;
    sr_data_d = sr_data_q;
    sr_err_d  = sr_err_q;
`ifdef LOGIC_OP_XCHK_EN
    or_xz_d   = or_xz_q;
    sr_xz_d   = sr_xz_q;
`endif
    cnt_d     = deliver_c ? cnt_q + CNT_W'(1) : cnt_q;

    case (state_q)
      EMPTY: begin
        if (accept_c) begin
          or_data_d = res_c;
          or_err_d  = err_c;
`ifdef LOGIC_OP_XCHK_EN
          or_xz_d   = xz_c;
`endif
          state_d   = ONE;
        end
      end
      ONE: begin
        if (accept_c && deliver_c) begin
          or_data_d = res_c;
          or_err_d  = err_c;
`ifdef LOGIC_OP_XCHK_EN
          or_xz_d   = xz_c;
`endif
        end else if (accept_c) begin
          sr_data_d = res_c;
          sr_err_d  = err_c;
`ifdef LOGIC_OP_XCHK_EN
          sr_xz_d   = xz_c;
`endif
          state_d   = FULL;
        end else if (deliver_c) begin
          state_d   = EMPTY;
        end
      end
      FULL: begin
        if (deliver_c) begin
          or_data_d = sr_data_q;
          or_err_d  = sr_err_q;
`ifdef LOGIC_OP_XCHK_EN
          or_xz_d   = sr_xz_q;
`endif
          state_d   = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flags registered from the next state so they line up with it.
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      or_data_q   <= '0;
      or_err_q    <= 1'b0;
      sr_data_q   <= '0;
      sr_err_q    <= 1'b0;
      cnt_q       <= '0;
`ifdef LOGIC_OP_XCHK_EN
      or_xz_q     <= 1'b0;
      sr_xz_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      or_data_q   <= or_data_d;
      or_err_q    <= or_err_d;
      sr_data_q   <= sr_data_d;
      sr_err_q    <= sr_err_d;
      cnt_q       <= cnt_d;
`ifdef LOGIC_OP_XCHK_EN
      or_xz_q     <= or_xz_d;
      sr_xz_q     <= sr_xz_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = or_data_q;
  assign out_err   = or_err_q;
  assign op_count  = cnt_q;
`ifdef LOGIC_OP_XCHK_EN
  assign xz_flag   = or_xz_q;
`endif

endmodule

// File: tb/tb_logic_op_pipe.sv
// Scoreboard bench for logic_op_pipe (WIDTH=4, CNT_W=4): stimulus pushes
// expected results, a negedge monitor pops and compares on every delivery.

module tb_logic_op_pipe;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 4;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [3:0]       in_op = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_err;
  logic [CNT_W-1:0] op_count;
`ifdef LOGIC_OP_XCHK_EN
  logic             xz_flag;
`endif

  exp_t             sb_q[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  int               n_cmp = 0;
  int               n_fail = 0;

  logic_op_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
`ifdef LOGIC_OP_XCHK_EN
    .xz_flag   (xz_flag),
`endif
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one beat from a negedge, hold until accepted, record its expectation.
  task automatic send(input logic [3:0] op, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] d,
                      input logic e);
    exp_t x;
    int   n;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send_timeout", 64'(in_ready), 64'd1);
    x.data = d;
    x.err  = e;
    sb_q.push_back(x);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) check("drain_timeout", 64'(sb_q.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 out_ready = r;
  endtask

  // Monitor: compare each delivered beat and the counter before it steps.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_beat", 64'd1, 64'd0);
      end else begin
        exp_t x;
        x = sb_q.pop_front();
        check("out_data", 64'(out_data), 64'(x.data));
        check("out_err", 64'(out_err), 64'(x.err));
        check("op_count_run", 64'(op_count), 64'(exp_cnt));
        exp_cnt = exp_cnt + CNT_W'(1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_op_count", 64'(op_count), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);

    // First beat: AND, 1-cycle latency, counter after delivery.
    send(4'd1, 4'b0100, 4'b0011, 4'b0000, 1'b0);
    check("latency_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    check("count_after_first", 64'(op_count), 64'd1);

    send(4'd6, 4'd4, 4'd3, 4'b0001, 1'b0);
    send(4'd3, 4'd4, 4'd4, 4'b0000, 1'b0);
    send(4'd4, 4'd4, 4'd4, 4'b1111, 1'b0);
    drain();

    // Backpressure: fill OR and SR, third beat waits on in_ready.
    set_ready(1'b0);
    @(negedge clk);
    send(4'd0, 4'b0101, 4'b1000, 4'b1010, 1'b0);
    check("ready_after_one", 64'(in_ready), 64'd1);
    send(4'd2, 4'b0101, 4'b1000, 4'b1101, 1'b0);
    check("ready_after_two", 64'(in_ready), 64'd0);
    fork
      send(4'd10, 4'b0101, 4'b1000, 4'b0000, 1'b0);
      begin
        repeat (2) @(negedge clk);
        check("ready_held_low", 64'(in_ready), 64'd0);
        check("stall_data", 64'(out_data), 64'b1010);
        set_ready(1'b1);
      end
    join
    drain();

    // Illegal opcode still flows and is counted.
    send(4'd13, 4'b1111, 4'b1111, 4'b0000, 1'b1);
    drain();
    check("count_after_illegal", 64'(op_count), 64'd8);

    // Nine more deliveries: 17 total wraps the 4-bit counter to 1.
    for (int i = 0; i < 9; i++) send(4'd11, 4'(i), 4'b1111, ~4'(i), 1'b0);
    drain();
    check("count_wrap", 64'(op_count), 64'd1);

    // Reset while FULL discards both held beats.
    set_ready(1'b0);
    @(negedge clk);
    send(4'd7, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    send(4'd8, 4'b1111, 4'b0000, 4'b0001, 1'b0);
    check("full_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_op_count", 64'(op_count), 64'd0);
    sb_q.delete();
    exp_cnt = '0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);

    send(4'd5, 4'b0000, 4'b1010, 4'b0001, 1'b0);
    send(4'd9, 4'b0000, 4'b1010, 4'b0000, 1'b0);
    send(4'd12, 4'b1010, 4'b0101, 4'b0000, 1'b1);
    send(4'd7, 4'b0000, 4'b0100, 4'b0001, 1'b0);
    drain();
    check("count_after_reset", 64'(op_count), 64'd4);

`ifdef LOGIC_OP_XCHK_EN
    send(4'd1, 4'bxz1x, 4'bx11x, 4'bxx1x, 1'b0);
    check("xz_set", 64'(xz_flag), 64'd1);
    drain();
    send(4'd8, 4'b1111, 4'b0000, 4'b0001, 1'b0);
    check("xz_clear", 64'(xz_flag), 64'd0);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
